// File: rtl/cas_mag_cmp_pkg.sv
// rtl/cas_mag_cmp_pkg.sv - shared types for the cascadable magnitude comparator
package cas_mag_cmp_pkg;

  // Upper bound on WIDTH that a single stage is intended to support.
  localparam int unsigned CMP_WIDTH_MAX = 64;

  // One comparison result. In steady state exactly one field is set; the
  // all-zero value appears only as the registered reset state.
  typedef struct packed {
    logic ab;  // A greater
    logic eq;  // equal
    logic ba;  // B greater
  } cmp_res_t;

  localparam cmp_res_t CMP_RES_RESET = '{ab: 1'b0, eq: 1'b0, ba: 1'b0};

  // Build a result from the two cascade-style flags. EQ is defined as
  // "neither side greater", so the result is one-hot whenever ab/ba are
  // mutually exclusive.
  function automatic cmp_res_t cmp_res_from_flags(input logic ab, input logic ba);
    cmp_res_t r;
    r.ab = ab;
    r.ba = ba;
    r.eq = ~ab & ~ba;
    return r;
  endfunction

endpackage

// File: rtl/cas_mag_cmp_bit.sv
// rtl/cas_mag_cmp_bit.sv - one-bit cascadable magnitude compare cell
//
// Ports:
//   A, B     operand bits at this position
//   ABI, BAI cascade in from the more-significant position
//   AB, BA   cascade out: A greater / B greater so far
//
// A decision made at a more-significant position always wins. ABI has
// priority over BAI so the illegal ABI=BAI=1 input still yields a one-hot
// result (AB=1).
module cas_mag_cmp_bit (
  input  logic A,
  input  logic B,
  input  logic ABI,
  input  logic BAI,
  output logic AB,
  output logic BA
);

  assign AB = ABI | (~BAI & A & ~B);
  assign BA = ~ABI & (BAI | (~A & B));

endmodule

// File: rtl/cas_mag_cmp.sv
// rtl/cas_mag_cmp.sv - WIDTH-bit cascadable magnitude comparator with registered copy
//
// Parameters:
//   WIDTH  operand bits compared by this stage (1..64)
//
// Ports:
//   clk            rising-edge clock for the registered result
//   rst            asynchronous active-high reset of the registered result
//   A, B           operand slices, MSB most significant
//   ABI, BAI       cascade in from the more-significant stage
//   AB, EQ, BA     combinational result including cascade (one-hot)
//   AB_q,EQ_q,BA_q registered copy of AB/EQ/BA, all zero while in reset
//
// The compare path is a ripple of bit cells from MSB to LSB with no state,
// so stages can be chained by feeding AB/BA into the next stage's ABI/BAI.
module cas_mag_cmp
  import cas_mag_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ABI,
  input  logic             BAI,
  output logic             AB,
  output logic             EQ,
  output logic             BA,
  output logic             AB_q,
  output logic             EQ_q,
  output logic             BA_q
);

  // ab_chain[i+1]/ba_chain[i+1] enter the cell at bit i; index WIDTH is the
  // external cascade input and index 0 is the final decision after the LSB.
  logic [WIDTH:0] ab_chain;
  logic [WIDTH:0] ba_chain;

  assign ab_chain[WIDTH] = ABI;
  assign ba_chain[WIDTH] = BAI;

  for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_bit
    cas_mag_cmp_bit u_bit (
      .A   (A[i]),
      .B   (B[i]),
      .ABI (ab_chain[i+1]),
      .BAI (ba_chain[i+1]),
      .AB  (ab_chain[i]),
      .BA  (ba_chain[i])
    );
  end

  cmp_res_t res_d;
  cmp_res_t res_q;

  assign res_d = cmp_res_from_flags(ab_chain[0], ba_chain[0]);

  assign AB = res_d.ab;
  assign EQ = res_d.eq;
  assign BA = res_d.ba;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= CMP_RES_RESET;
    end else begin
      res_q <= res_d;
    end
  end

  assign AB_q = res_q.ab;
  assign EQ_q = res_q.eq;
  assign BA_q = res_q.ba;

endmodule

// File: tb/tb_cas_mag_cmp.sv
// tb/tb_cas_mag_cmp.sv - self-checking bench for cas_mag_cmp
module tb_cas_mag_cmp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Single-bit stage
  logic a1 = 1'b0, b1 = 1'b0, abi1 = 1'b0, bai1 = 1'b0;
  logic ab1, eq1, ba1, ab1_q, eq1_q, ba1_q;

  // 32-bit single stage
  logic [31:0] a32 = '0, b32 = '0;
  logic abi32 = 1'b0, bai32 = 1'b0;
  logic ab32, eq32, ba32, ab32_q, eq32_q, ba32_q;

  // 32-stage chain of 1-bit stages sharing a32/b32, first stage ABI=BAI=0
  logic [32:0] ch_ab, ch_ba;
  logic [31:0] ch_eq, ch_ab_q, ch_eq_q, ch_ba_q;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_en = 1'b0;

  cas_mag_cmp #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .ABI(abi1), .BAI(bai1),
    .AB(ab1), .EQ(eq1), .BA(ba1), .AB_q(ab1_q), .EQ_q(eq1_q), .BA_q(ba1_q)
  );

  cas_mag_cmp #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .A(a32), .B(b32), .ABI(abi32), .BAI(bai32),
    .AB(ab32), .EQ(eq32), .BA(ba32), .AB_q(ab32_q), .EQ_q(eq32_q), .BA_q(ba32_q)
  );

  assign ch_ab[0] = 1'b0;
  assign ch_ba[0] = 1'b0;

  for (genvar k = 0; k < 32; k++) begin : g_chain
    cas_mag_cmp #(.WIDTH(1)) u_stage (
      .clk(clk), .rst(rst), .A(a32[31-k]), .B(b32[31-k]),
      .ABI(ch_ab[k]), .BAI(ch_ba[k]),
      .AB(ch_ab[k+1]), .EQ(ch_eq[k]), .BA(ch_ba[k+1]),
      .AB_q(ch_ab_q[k]), .EQ_q(ch_eq_q[k]), .BA_q(ch_ba_q[k])
    );
  end

  // Reference: result as {AB,EQ,BA} from plain unsigned arithmetic.
  function automatic logic [2:0] mdl(input logic [63:0] a, input logic [63:0] b,
                                     input logic abi, input logic bai);
    if (abi) return 3'b100;
    if (bai) return 3'b001;
    if (a > b) return 3'b100;
    if (a < b) return 3'b001;
    return 3'b010;
  endfunction

  // Expected registered copies.
  logic [2:0] exp1_q, exp32_q, expch_q;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp1_q  <= 3'b000;
      exp32_q <= 3'b000;
      expch_q <= 3'b000;
    end else begin
      exp1_q  <= mdl({63'd0, a1}, {63'd0, b1}, abi1, bai1);
      exp32_q <= mdl({32'd0, a32}, {32'd0, b32}, abi32, bai32);
      expch_q <= mdl({32'd0, a32}, {32'd0, b32}, 1'b0, 1'b0);
    end
  end

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got {AB,EQ,BA}=%b expected %b at %0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("w1_comb",   {ab1, eq1, ba1},   mdl({63'd0, a1}, {63'd0, b1}, abi1, bai1));
      chk("w32_comb",  {ab32, eq32, ba32}, mdl({32'd0, a32}, {32'd0, b32}, abi32, bai32));
      chk("chain_comb", {ch_ab[32], ch_eq[31], ch_ba[32]},
          mdl({32'd0, a32}, {32'd0, b32}, 1'b0, 1'b0));
      chk("w1_q",      {ab1_q, eq1_q, ba1_q},   exp1_q);
      chk("w32_q",     {ab32_q, eq32_q, ba32_q}, exp32_q);
      chk("chain_q",   {ch_ab_q[31], ch_eq_q[31], ch_ba_q[31]}, expch_q);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply1(input string name, input logic a, input logic b,
                        input logic abi, input logic bai, input logic [2:0] exp);
    a1 = a; b1 = b; abi1 = abi; bai1 = bai;
    #1;
    chk(name, {ab1, eq1, ba1}, exp);
    step();
  endtask

  task automatic apply32(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] exp);
    a32 = a; b32 = b; abi32 = 1'b0; bai32 = 1'b0;
    #1;
    chk({name, "_chain"}, {ch_ab[32], ch_eq[31], ch_ba[32]}, exp);
    chk({name, "_w32"},   {ab32, eq32, ba32}, exp);
    step();
  endtask

  initial begin
    // Reset state: registered outputs zero, combinational live.
    #1;
    chk("rst_w1_q",    {ab1_q, eq1_q, ba1_q}, 3'b000);
    chk("rst_w32_q",   {ab32_q, eq32_q, ba32_q}, 3'b000);
    chk("rst_chain_q", {ch_ab_q[31], ch_eq_q[31], ch_ba_q[31]}, 3'b000);
    chk("rst_w1_comb", {ab1, eq1, ba1}, 3'b010);
    step();
    chk("rst_hold_w1_q", {ab1_q, eq1_q, ba1_q}, 3'b000);
    rst = 1'b0;
    chk_en = 1'b1;
    step();
    chk("rel_w1_q", {ab1_q, eq1_q, ba1_q}, 3'b010);

    // One-bit truth table and cascade priority.
    apply1("w1_00", 1'b0, 1'b0, 1'b0, 1'b0, 3'b010);
    apply1("w1_10", 1'b1, 1'b0, 1'b0, 1'b0, 3'b100);
    apply1("w1_01", 1'b0, 1'b1, 1'b0, 1'b0, 3'b001);
    apply1("w1_11", 1'b1, 1'b1, 1'b0, 1'b0, 3'b010);
    apply1("w1_abi", 1'b0, 1'b1, 1'b1, 1'b0, 3'b100);
    apply1("w1_bai", 1'b1, 1'b0, 1'b0, 1'b1, 3'b001);
    apply1("w1_both", 1'b0, 1'b1, 1'b1, 1'b1, 3'b100);

    // 32-bit compare via chain and wide stage.
    apply32("deadbeef", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b010);
    apply32("msb",      32'h8000_0000, 32'h7FFF_FFFF, 3'b100);
    apply32("lsb",      32'h0000_0001, 32'h0000_0002, 3'b001);
    apply32("ones_lo",  32'hFFFF_FFFE, 32'hFFFF_FFFF, 3'b001);
    apply32("zero",     32'h0000_0000, 32'h0000_0000, 3'b010);

    // Wide stage cascade override.
    a32 = 32'h0000_0001; b32 = 32'hFFFF_FFFF; abi32 = 1'b1;
    #1;
    chk("w32_abi", {ab32, eq32, ba32}, 3'b100);
    step();
    abi32 = 1'b0; bai32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'h0;
    #1;
    chk("w32_bai", {ab32, eq32, ba32}, 3'b001);
    step();
    bai32 = 1'b0;

    // Mixed run, roughly half the operands equal; reset pulse in the middle.
    for (int i = 0; i < 60; i++) begin
      a32 = $urandom;
      b32 = ($urandom_range(0, 1) == 1) ? a32 : $urandom;
      a1 = 1'($urandom_range(0, 1));
      b1 = ($urandom_range(0, 1) == 1) ? a1 : 1'($urandom_range(0, 1));
      abi1 = ($urandom_range(0, 7) == 0);
      bai1 = ($urandom_range(0, 7) == 0);
      abi32 = 1'b0;
      bai32 = ($urandom_range(0, 7) == 0);
      if (i == 30) begin
        rst = 1'b1;
        #1;
        chk("mid_rst_w1_q",    {ab1_q, eq1_q, ba1_q}, 3'b000);
        chk("mid_rst_w32_q",   {ab32_q, eq32_q, ba32_q}, 3'b000);
        chk("mid_rst_chain_q", {ch_ab_q[31], ch_eq_q[31], ch_ba_q[31]}, 3'b000);
        chk("mid_rst_comb",    {ch_ab[32], ch_eq[31], ch_ba[32]},
            mdl({32'd0, a32}, {32'd0, b32}, 1'b0, 1'b0));
        step();
        rst = 1'b0;
        step();
        chk("post_rst_chain_q", {ch_ab_q[31], ch_eq_q[31], ch_ba_q[31]},
            mdl({32'd0, a32}, {32'd0, b32}, 1'b0, 1'b0));
      end else begin
        step();
      end
    end

    step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
